// File: rtl/booth_sequencer.sv
// Radix-2 Booth multiply sequencer: owns the A/Q/Q(-1)/M registers and iteration control, the add/shift step is external.
// Optional BOOTH_MINNEG_FLAG_EN adds an ovf output flagging multiplicand == -128.
module booth_sequencer (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic signed [7:0]  multiplier,
    input  logic signed [7:0]  multiplicand,
    output logic signed [7:0]  acc_q,
    output logic signed [7:0]  q_q,
    output logic               q0_q,
    output logic signed [7:0]  mcand_q,
    input  logic signed [7:0]  acc_next,
    input  logic signed [7:0]  q_next,
    input  logic               q0_next,
    output logic               busy,
    output logic               done,
`ifdef BOOTH_MINNEG_FLAG_EN
    output logic               ovf,
`endif
    output logic signed [15:0] product
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t     state;
    logic [2:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            acc_q   <= '0;
            q_q     <= '0;
            q0_q    <= 1'b0;
            mcand_q <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
`ifdef BOOTH_MINNEG_FLAG_EN
            ovf     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc_q   <= '0;
                        q_q     <= multiplier;
                        q0_q    <= 1'b0;
                        mcand_q <= multiplicand;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
`ifdef BOOTH_MINNEG_FLAG_EN
                        // -M overflows the 8-bit accumulator when M is the most negative value
                        ovf     <= (multiplicand == 8'sh80);
`endif
                    end
                end
                RUN: begin
                    acc_q <= acc_next;
                    q_q   <= q_next;
                    q0_q  <= q0_next;
                    cnt   <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        product <= {acc_next, q_next};
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_sequencer.sv
// Bench for booth_sequencer: supplies the Booth add/shift step and checks products against plain signed multiplication.
module tb_booth_sequencer;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic signed [7:0]  multiplier, multiplicand;
    logic signed [7:0]  acc_q, q_q, mcand_q;
    logic               q0_q;
    logic signed [7:0]  acc_next, q_next;
    logic               q0_next;
    logic               busy, done;
    logic signed [15:0] product;
`ifdef BOOTH_MINNEG_FLAG_EN
    logic               ovf;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    logic signed [15:0] prev_prod;

    booth_sequencer dut (
        .clk(clk), .rst(rst), .start(start),
        .multiplier(multiplier), .multiplicand(multiplicand),
        .acc_q(acc_q), .q_q(q_q), .q0_q(q0_q), .mcand_q(mcand_q),
        .acc_next(acc_next), .q_next(q_next), .q0_next(q0_next),
        .busy(busy), .done(done),
`ifdef BOOTH_MINNEG_FLAG_EN
        .ovf(ovf),
`endif
        .product(product)
    );

    always #5 clk = ~clk;

    // External Booth step stage: add/subtract M per {Q0,Q-1}, then arithmetic shift right of {A,Q,Q-1}
    logic signed [7:0] sum;
    always_comb begin
        sum = acc_q;
        if (q_q[0] && !q0_q)      sum = acc_q - mcand_q;
        else if (!q_q[0] && q0_q) sum = acc_q + mcand_q;
        acc_next = {sum[7], sum[7:1]};
        q_next   = {sum[0], q_q[7:1]};
        q0_next  = q_q[0];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_acc"},   32'(acc_q),   32'd0);
        chk({tag, "_q"},     32'(q_q),     32'd0);
        chk({tag, "_q0"},    32'(q0_q),    32'd0);
        chk({tag, "_mcand"}, 32'(mcand_q), 32'd0);
        chk({tag, "_busy"},  32'(busy),    32'd0);
        chk({tag, "_done"},  32'(done),    32'd0);
        chk({tag, "_prod"},  32'(product), 32'd0);
`ifdef BOOTH_MINNEG_FLAG_EN
        chk({tag, "_ovf"},   32'(ovf),     32'd0);
`endif
    endtask

    // One operation; pulse_at/rst_at give the RUN cycle index for a stray start or a reset (-1 = none)
    task automatic run_op(input string tag, input logic signed [7:0] a, input logic signed [7:0] b,
                          input bit chk_prod, input logic signed [15:0] exp_p,
                          input int pulse_at, input int rst_at);
        int k;
        int busy_n;
        @(negedge clk);
        multiplier = a; multiplicand = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        multiplier = 8'($urandom); multiplicand = 8'($urandom);
        k = 0; busy_n = 0;
        while (!done && k < 20) begin
            if (busy) busy_n++;
            chk({tag, "_mcand_hold"}, 32'(mcand_q), 32'(b));
            chk({tag, "_prod_hold"},  32'(product), 32'(prev_prod));
            if (k == rst_at) begin
                rst = 1'b1; #1;
                chk_zero_outputs({tag, "_async_rst"});
                repeat (3) begin
                    @(posedge clk); #1;
                    chk({tag, "_no_done_in_rst"}, 32'(done), 32'd0);
                end
                @(negedge clk); rst = 1'b0;
                prev_prod = '0;
                return;
            end
            if (k == pulse_at) begin
                start = 1'b1; multiplier = 8'($urandom); multiplicand = 8'($urandom);
            end
            @(posedge clk); #1;
            start = 1'b0;
            k++;
        end
        if (busy) busy_n++;
        chk({tag, "_latency"}, 32'(k), 32'd8);
        chk({tag, "_busy_cycles"}, 32'(busy_n), 32'd9);
        if (chk_prod) chk({tag, "_product"}, 32'(product), 32'(exp_p));
`ifdef BOOTH_MINNEG_FLAG_EN
        chk({tag, "_ovf"}, 32'(ovf), 32'(b == 8'sh80));
`endif
        prev_prod = product;
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_idle_busy"},  32'(busy), 32'd0);
        // A stray start must not have queued a second operation
        repeat (12) begin
            @(posedge clk); #1;
            if (pulse_at >= 0) chk({tag, "_single_done"}, 32'(done), 32'd0);
        end
    endtask

    initial begin
        int k;
        logic signed [7:0] a, b;
        rst = 1'b1; start = 1'b0; multiplier = '0; multiplicand = '0;
        prev_prod = '0;
        #12;
        chk_zero_outputs("reset");
        @(negedge clk); rst = 1'b0;

        run_op("p3x5",     8'sd3,    8'sd5,    1'b1, 16'h000F, -1, -1);
        run_op("m3x5",    -8'sd3,    8'sd5,    1'b1, 16'hFFF1, -1, -1);
        run_op("127x127",  8'sd127,  8'sd127,  1'b1, 16'h3F01, -1, -1);
        run_op("m128x1",   8'sh80,   8'sd1,    1'b1, 16'hFF80, -1, -1);
        run_op("x_m128",   8'sd5,    8'sh80,   1'b0, 16'h0000, -1, -1);
        run_op("stray",    8'sd7,   -8'sd9,    1'b1, 16'hFFC1,  3, -1);
        run_op("abort",    8'sd11,   8'sd13,   1'b0, 16'h0000, -1,  4);
        run_op("p2xm2",    8'sd2,   -8'sd2,    1'b1, 16'hFFFC, -1, -1);

        // Held-high start: second operation launches on the first edge back in IDLE
        @(negedge clk); multiplier = 8'sd6; multiplicand = -8'sd4; start = 1'b1;
        k = 0;
        do begin @(posedge clk); #1; k++; end while (!done && k < 20);
        chk("b2b_first_latency", 32'(k), 32'd9);
        chk("b2b_first_prod", 32'(product), 32'(16'shFFE8));
        @(posedge clk); @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_relaunch_busy", 32'(busy), 32'd1);
        k = 0;
        do begin @(posedge clk); #1; k++; end while (!done && k < 20);
        chk("b2b_second_latency", 32'(k), 32'd8);
        chk("b2b_second_prod", 32'(product), 32'(16'shFFE8));
        prev_prod = product;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 16; i++) begin
            a = 8'($urandom);
            do b = 8'($urandom); while (b == 8'sh80);
            run_op("rand", a, b, 1'b1, 16'(int'(a) * int'(b)), -1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/booth_sequencer.md
BOOTH_SEQUENCER -- requirements
Module: booth_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have port start, input, 1 bit: request a multiply; sampled only in IDLE.
REQ-004 SHALL have port multiplier, input, signed 8 bits: Q operand, captured on accepted start.
REQ-005 SHALL have port multiplicand, input, signed 8 bits: M operand, captured on accepted start.
REQ-006 SHALL have port acc_q, output, signed 8 bits: accumulator register, fed to the Booth step stage.
REQ-007 SHALL have port q_q, output, signed 8 bits: Q register, fed to the Booth step stage.
REQ-008 SHALL have port q0_q, output, 1 bit: Q(-1) register, fed to the Booth step stage.
REQ-009 SHALL have port mcand_q, output, signed 8 bits: latched multiplicand, fed to the Booth step stage.
REQ-010 SHALL have port acc_next, input, signed 8 bits: next accumulator value returned by the step stage.
REQ-011 SHALL have port q_next, input, signed 8 bits: next Q value returned by the step stage.
REQ-012 SHALL have port q0_next, input, 1 bit: next Q(-1) value returned by the step stage.
REQ-013 SHALL have port busy, output, 1 bit: high in RUN and DONE.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse when product is valid.
REQ-015 SHALL have port product, output, signed 16 bits: {acc, Q} result, held until the next accepted start.

Function
REQ-016 SHALL implement an FSM with states IDLE, RUN and DONE, plus a 3-bit iteration counter.
REQ-017 In IDLE with start=1 at a clk edge, the block SHALL load acc_q=0, q_q=multiplier, q0_q=0, mcand_q=multiplicand, counter=0, and enter RUN.
REQ-018 In RUN, each edge SHALL load acc_q<=acc_next, q_q<=q_next, q0_q<=q0_next, and counter<=counter+1.
REQ-019 On the RUN edge where counter==7 (the eighth update), the FSM SHALL enter DONE and register product<={acc_next,q_next}.
REQ-020 DONE SHALL last exactly one cycle with done=1, then the FSM SHALL return to IDLE.
REQ-021 With start accepted at edge E0, done SHALL be high in the cycle after E8 (9-cycle latency), and start SHALL be ready again after E9.
REQ-022 start in RUN or DONE SHALL be ignored, with no queuing; held-high start in IDLE SHALL launch back-to-back operations.
REQ-023 Operand inputs SHALL be don't-care except on the accepting edge; mcand_q SHALL stay stable through RUN.
REQ-024 The counter SHALL not wrap visibly: it is cleared on load, and its value in DONE and IDLE is irrelevant.
REQ-025 product SHALL update only at the REQ-019 edge, and SHALL otherwise hold.

Reset
REQ-026 rst=1 SHALL immediately force IDLE and set acc_q=0, q_q=0, q0_q=0, mcand_q=0, counter=0, busy=0, done=0 and product=0.
REQ-027 Reset mid-RUN SHALL abort the operation with no done pulse; the first edge after release with start=1 SHALL start cleanly.

Configuration
REQ-028 Macro BOOTH_MINNEG_FLAG_EN defined: the block SHALL add output ovf (1 bit), registered on accepted start as (multiplicand==-128), held until the next start, reset 0; it flags results invalid from the 8-bit accumulator.
REQ-029 Macro BOOTH_MINNEG_FLAG_EN undefined: the ovf port and its logic SHALL be absent, with all other behaviour identical.

Verification
REQ-030 The bench SHALL check: multiplier=3, multiplicand=5, start -> done after 9 cycles, product=0x000F, busy high for 9 cycles.
REQ-031 The bench SHALL check: multiplier=-3, multiplicand=5 -> product=0xFFF1; multiplier=127, multiplicand=127 -> product=0x3F01.
REQ-032 The bench SHALL check: multiplier=-128, multiplicand=1 -> product=0xFF80; with BOOTH_MINNEG_FLAG_EN, multiplicand=-128 -> ovf=1.
REQ-033 The bench SHALL check: start pulsed again at cycle 4 of RUN -> ignored, a single done, and product matches the first operands.
REQ-034 The bench SHALL check: rst asserted at RUN cycle 5 -> all outputs 0 asynchronously, no done; next start with 2*-2 -> product=0xFFFC.
